pdm_dac_stereo: RTL and testbench

Stereo audio back-end that accepts signed 16-bit left/right sample pairs from the RISC-V system over a valid/ready handshake. Pairs are buffered in a small FIFO and released at a fixed audio rate. Each channel is converted to a 1-bit first-order sigma-delta PDM stream. The stream drives the filter/amp PMOD pins (pdm[0]=left, pdm[1]=right) and runs in the clk24 domain.

---
 rtl/pdm_dac_stereo.sv | 131 +++++++++++++
 tb/tb_pdm_dac_stereo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_dac_stereo.sv
// rtl/pdm_dac_stereo.sv - stereo sample FIFO, audio-rate pop and first-order sigma-delta PDM outputs
//
// Purpose: accepts signed left/right sample pairs over a valid/ready handshake,
// buffers them in a small FIFO, releases one pair per RATE_DIV clk cycles into
// offset-binary hold registers and converts each channel to a 1-bit PDM stream.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   enable        1 = run rate counter and modulators, 0 = idle
//   s_valid       upstream pair valid
//   s_ready       FIFO can accept a pair
//   s_left        left sample, signed DW bits
//   s_right       right sample, signed DW bits
//   fifo_level    pairs currently stored
//   underrun      sticky: a rate tick found the FIFO empty
//   underrun_clr  single-cycle clear of underrun (a same-cycle set wins)
//   pdm           PDM bitstreams, [0]=left, [1]=right
module pdm_dac_stereo #(
    parameter int DW       = 16,
    parameter int FIFO_AW  = 2,
    parameter int RATE_DIV = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_left,
    input  logic [DW-1:0]      s_right,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun,
    input  logic               underrun_clr,
    output logic [1:0]         pdm
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(RATE_DIV);

    logic [CW-1:0]      rate_cnt;
    logic [2*DW-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [DW-1:0]      hold_l;
    logic [DW-1:0]      hold_r;
    logic [DW-1:0]      acc_l;
    logic [DW-1:0]      acc_r;

    logic               tick;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [2*DW-1:0]    head;
    logic [DW:0]        sum_l;
    logic [DW:0]        sum_r;

    assign tick       = enable && (rate_cnt == CW'(RATE_DIV - 1));
    // Ready is derived from the registered count only, so a full FIFO stays
    // closed on a tick cycle even though a slot frees at that edge.
    assign s_ready    = (level != (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty = (level == '0);
    assign push       = s_valid && s_ready;
    assign pop        = tick && !fifo_empty;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    // The carry out of the accumulator is the PDM bit; its density is hold/2**DW.
    assign sum_l = {1'b0, acc_l} + {1'b0, hold_l};
    assign sum_r = {1'b0, acc_r} + {1'b0, hold_r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            hold_l   <= '0;
            hold_r   <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            pdm      <= 2'b00;
            underrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (!enable || tick) begin
                rate_cnt <= '0;
            end else begin
                rate_cnt <= rate_cnt + CW'(1);
            end

            if (push) begin
                mem[wr_ptr] <= {s_left, s_right};
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end

            // Pop converts two's complement to offset binary by flipping the MSB.
            if (pop) begin
                hold_l <= {~head[2*DW-1], head[2*DW-2:DW]};
                hold_r <= {~head[DW-1], head[DW-2:0]};
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW + 1)'(1);
                2'b01:   level <= level - (FIFO_AW + 1)'(1);
                default: level <= level;
            endcase

            if (tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            // A freshly popped value is first accumulated on the following edge.
            if (enable) begin
                acc_l <= sum_l[DW-1:0];
                acc_r <= sum_r[DW-1:0];
                pdm   <= {sum_r[DW], sum_l[DW]};
            end else begin
                acc_l <= '0;
                acc_r <= '0;
                pdm   <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_pdm_dac_stereo.sv
// tb/tb_pdm_dac_stereo.sv - scoreboard bench for pdm_dac_stereo with a behavioural reference model
module tb_pdm_dac_stereo;

    localparam int DW       = 16;
    localparam int FIFO_AW  = 2;
    localparam int RATE_DIV = 500;
    localparam int DEPTH    = 4;
    localparam int FULL_SC  = 65536;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_left;
    logic [DW-1:0]     s_right;
    logic [FIFO_AW:0]  fifo_level;
    logic              underrun;
    logic              underrun_clr;
    logic [1:0]        pdm;

    pdm_dac_stereo #(.DW(DW), .FIFO_AW(FIFO_AW), .RATE_DIV(RATE_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .pdm          (pdm)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue of accepted pairs, holds are plain
    // integers in 0..65535, and each PDM bit is the overflow of a running sum.
    logic [31:0]        m_q[$];
    int                 m_cnt;
    int                 m_hold_l, m_hold_r;
    int                 m_acc_l, m_acc_r;
    bit [1:0]           m_pdm;
    bit                 m_underrun;
    bit                 m_tick, m_empty, m_full;
    int                 m_sum;
    logic [31:0]        m_pair;
    logic signed [15:0] m_sl, m_sr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_cnt = 0; m_hold_l = 0; m_hold_r = 0;
            m_acc_l = 0; m_acc_r = 0; m_pdm = 2'b00; m_underrun = 1'b0;
        end else begin
            m_tick  = enable && (m_cnt == RATE_DIV - 1);
            m_empty = (m_q.size() == 0);
            m_full  = (m_q.size() == DEPTH);
            if (enable) begin
                m_sum = m_acc_l + m_hold_l;
                m_pdm[0] = (m_sum >= FULL_SC);
                m_acc_l = m_sum % FULL_SC;
                m_sum = m_acc_r + m_hold_r;
                m_pdm[1] = (m_sum >= FULL_SC);
                m_acc_r = m_sum % FULL_SC;
            end else begin
                m_acc_l = 0; m_acc_r = 0; m_pdm = 2'b00;
            end
            if (m_tick && !m_empty) begin
                m_pair = m_q.pop_front();
                m_sl = m_pair[31:16];
                m_sr = m_pair[15:0];
                m_hold_l = int'(m_sl) + 32768;
                m_hold_r = int'(m_sr) + 32768;
            end
            if (m_tick && m_empty) m_underrun = 1'b1;
            else if (underrun_clr) m_underrun = 1'b0;
            if (s_valid && !m_full) m_q.push_back({s_left, s_right});
            m_cnt = !enable ? 0 : (m_cnt == RATE_DIV - 1) ? 0 : m_cnt + 1;
        end
    end

    // Monitor: compares the DUT against the model every cycle, away from the edge.
    always @(negedge clk) begin
        check("fifo_level", int'(fifo_level), m_q.size());
        check("s_ready", int'(s_ready), (m_q.size() != DEPTH) ? 1 : 0);
        check("underrun", int'(underrun), int'(m_underrun));
        check("pdm", int'(pdm), int'(m_pdm));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 2000) begin
            cyc(1);
            n++;
        end
        check("wait_cnt_timeout", (n < 2000) ? 1 : 0, 1);
    endtask

    task automatic wait_hold(input int l, input int r);
        int n = 0;
        while ((m_hold_l != l || m_hold_r != r) && n < 2000) begin
            cyc(1);
            n++;
        end
        check("wait_hold_timeout", (n < 2000) ? 1 : 0, 1);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1; s_left = l; s_right = r;
        cyc(1);
        s_valid = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ol, output int o_r);
        ol = 0; o_r = 0;
        repeat (n) begin
            cyc(1);
            ol  += int'(pdm[0]);
            o_r += int'(pdm[1]);
        end
    endtask

    int ones_l, ones_r, n_wait;

    initial begin
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
        s_left = '0; s_right = '0;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Reset mid-stream with three pairs buffered.
        for (int i = 0; i < 3; i++) push_pair(16'($urandom), 16'($urandom));
        cyc(1);
        check("level_before_reset", int'(fifo_level), 3);
        #3 reset = 1'b1;
        #1;
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(s_ready), 1);
        check("rst_underrun", int'(underrun), 0);
        check("rst_pdm", int'(pdm), 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Midscale: hold 0x8000 gives exactly half density.
        push_pair(16'h0000, 16'h0000);
        enable = 1'b1;
        wait_hold(32768, 32768);
        cyc(2);
        count_ones(16, ones_l, ones_r);
        check("mid_ones_left", ones_l, 8);
        check("mid_ones_right", ones_r, 8);

        // Extremes: max positive left, max negative right.
        push_pair(16'h7FFF, 16'h8000);
        wait_hold(65535, 0);
        cyc(2);
        count_ones(65536, ones_l, ones_r);
        check("max_ones_left", ones_l, 65535);
        check("min_ones_right", ones_r, 0);

        // Underrun is sticky; clear off-tick works, clear on an empty tick loses.
        check("underrun_set", int'(underrun), 1);
        wait_cnt(10);
        underrun_clr = 1'b1; cyc(1); underrun_clr = 1'b0;
        check("underrun_cleared", int'(underrun), 0);
        wait_cnt(RATE_DIV - 1);
        underrun_clr = 1'b1; cyc(1); underrun_clr = 1'b0;
        check("underrun_set_wins", int'(underrun), 1);

        // Fill while idle: the fifth pair is refused.
        enable = 1'b0;
        cyc(1);
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_left = 16'($urandom); s_right = 16'($urandom);
            cyc(1);
        end
        s_valid = 1'b0;
        cyc(1);
        check("full_level", int'(fifo_level), 4);
        check("full_ready", int'(s_ready), 0);
        enable = 1'b1;
        n_wait = 0;
        while (m_q.size() != 3 && n_wait < 1000) begin cyc(1); n_wait++; end
        check("first_pop_wait", n_wait, RATE_DIV);
        check("ready_after_pop", int'(s_ready), 1);
        check("level_after_pop", int'(fifo_level), 3);

        // Full FIFO with s_valid held across a tick: no bypass, refill next cycle.
        s_valid = 1'b1; s_left = 16'($urandom); s_right = 16'($urandom);
        cyc(1);
        check("refilled_level", int'(fifo_level), 4);
        wait_cnt(RATE_DIV - 1);
        check("tick_cycle_ready", int'(s_ready), 0);
        cyc(1);
        check("after_tick_level", int'(fifo_level), 3);
        cyc(1);
        check("push_next_level", int'(fifo_level), 4);
        s_valid = 1'b0;

        // Random traffic, occasional clears and an idle interval.
        for (int i = 0; i < 6000; i++) begin
            s_valid      = ($urandom_range(0, 299) == 0);
            s_left       = 16'($urandom);
            s_right      = 16'($urandom);
            underrun_clr = ($urandom_range(0, 199) == 0);
            if (i == 3000) enable = 1'b0;
            if (i == 3100) enable = 1'b1;
            cyc(1);
        end
        s_valid = 1'b0; underrun_clr = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
